btn_conditioner: RTL and testbench

- Conditions the two raw push-buttons (up/down) before they reach the 8-bit position counter that drives the servo PWM stage.
- Per button: synchronises, debounces, edge-detects, then generates single-cycle step pulses with hold-to-auto-repeat.
- Runs on the 25 MHz system clock.
- Replaces the divided-clock level sampling of buttons with clean clk-domain step strobes (up_pulse/down_pulse) for the position counter.

---
 rtl/btn_conditioner_if.sv | 21 ++
 rtl/btn_conditioner.sv | 122 ++++++++++++
 tb/tb_btn_conditioner.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Button conditioner bus: raw buttons in, debounced levels and step strobes out.
interface btn_conditioner_if;
  logic [1:0] btn;
  logic [1:0] btn_level;
  logic       up_pulse;
  logic       down_pulse;

  modport master (
    output btn,
    input  btn_level,
    input  up_pulse,
    input  down_pulse
  );

  modport slave (
    input  btn,
    output btn_level,
    output up_pulse,
    output down_pulse
  );
endinterface

// File: rtl/btn_conditioner.sv
// Up/down push-button conditioner: sync, debounce, and per-button step pulses
// with hold-to-auto-repeat, feeding the servo position counter.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic                clk,
  input  logic                rst,
  btn_conditioner_if.slave    bus
);

  localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] REP_LAST  = 24'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0] sync_p0;
  logic [1:0] sync_p1;
  logic [1:0] level;
  logic [1:0] step_due;
  logic       up_q;
  logic       down_q;

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= bus.btn;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_bit
    logic        lvl;
    logic [23:0] db_cnt;
    state_t      state;
    logic [23:0] timer;

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreement discards the partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        lvl    <= 1'b0;
        db_cnt <= 24'd0;
      end else if (sync_p1[i] == lvl) begin
        db_cnt <= 24'd0;
      end else if (db_cnt == DB_LAST) begin
        lvl    <= ~lvl;
        db_cnt <= 24'd0;
      end else begin
        db_cnt <= db_cnt + 24'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= IDLE;
        timer <= 24'd0;
      end else if (!lvl) begin
        state <= IDLE;
        timer <= 24'd0;
      end else begin
        case (state)
          IDLE: begin
            state <= DELAY;
            timer <= 24'd0;
          end
          DELAY: begin
            if (timer == HOLD_LAST) begin
              state <= REPEAT;
              timer <= 24'd0;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          REPEAT: begin
            if (timer == REP_LAST) begin
              timer <= 24'd0;
            end else begin
              timer <= timer + 24'd1;
            end
          end
          default: begin
            state <= IDLE;
            timer <= 24'd0;
          end
        endcase
      end
    end

    // A request is due on the same edge the FSM takes its step transition;
    // a low level (release) suppresses it.
    assign step_due[i] = lvl && ((state == IDLE) ||
                                 ((state == DELAY)  && (timer == HOLD_LAST)) ||
                                 ((state == REPEAT) && (timer == REP_LAST)));
    assign level[i] = lvl;
  end

  // Stage p2: registered, mutually exclusive step strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= step_due[0] && !(&level);
      down_q <= step_due[1] && !(&level);
    end
  end

  assign bus.btn_level  = level;
  assign bus.up_pulse   = up_q;
  assign bus.down_pulse = down_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomized button activity
// checked against a press-age based reference model.
module tb_btn_conditioner;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  logic [1:0] m_s1, m_s2, m_lvl;
  int         m_run [2];
  int         m_rise[2];
  logic       m_up, m_dn;

  // Pulse schedule from press age: first at age 0, then at H, H+R, H+2R, ...
  function automatic void model_edge();
    logic [1:0] due;
    logic       both;
    int         age;
    if (rst) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_lvl = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
      m_up = 1'b0;  m_dn = 1'b0;
      return;
    end
    both = m_lvl[0] && m_lvl[1];
    for (int i = 0; i < 2; i++) begin
      age = cyc - m_rise[i] - 1;
      due[i] = m_lvl[i] && ((age == 0) || ((age >= H) && ((age - H) % R == 0)));
    end
    m_up = due[0] && !both;
    m_dn = due[1] && !both;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == D) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
        if (m_lvl[i]) m_rise[i] = cyc;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.btn;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn = 2'b11;
    for (int n = 0; n < 3; n++) begin
      tick();
      n_vec++;
      if ({bus.btn_level, bus.up_pulse, bus.down_pulse} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_state n=%0d got lvl=%b up=%b dn=%b want 00/0/0",
                 n, bus.btn_level, bus.up_pulse, bus.down_pulse);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL reset_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
      if (n == 5 || n == 6) begin
        n_vec++;
        if (bus.btn_level !== ((n == 6) ? 2'b11 : 2'b00)) begin
          n_bad++;
          $display("FAIL reset_level_edge n=%0d got %b want %b", n, bus.btn_level,
                   (n == 6) ? 2'b11 : 2'b00);
        end
      end
      n_vec++;
      if (bus.up_pulse !== 1'b0 || bus.down_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_pulse n=%0d got up=%b dn=%b want 0/0", n,
                 bus.up_pulse, bus.down_pulse);
      end
    end
    bus.btn = 2'b00;
    for (int n = 0; n < 10; n++) tick();
  endtask

  task automatic test_hold_repeat();
    logic exp_up;
    bus.btn = 2'b01;
    for (int n = 1; n <= 60; n++) begin
      tick();
      exp_up = (n == 7 || n == 27 || n == 35 || n == 43 || n == 51 || n == 59);
      n_vec++;
      if (bus.up_pulse !== exp_up || bus.down_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_schedule n=%0d got up=%b dn=%b want up=%b dn=0", n,
                 bus.up_pulse, bus.down_pulse, exp_up);
      end
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL hold_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
      if (n == 5 || n == 6) begin
        n_vec++;
        if (bus.btn_level[0] !== (n == 6)) begin
          n_bad++;
          $display("FAIL hold_level_rise n=%0d got %b want %b", n, bus.btn_level[0], n == 6);
        end
      end
    end
    bus.btn = 2'b00;
    for (int n = 0; n < 12; n++) begin
      tick();
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL hold_release n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] bounce;
    bounce = 4'b0101;
    for (int n = 1; n <= 16; n++) begin
      bus.btn = {(n <= 4) ? bounce[n-1] : 1'b1, 1'b0};
      tick();
      n_vec++;
      if (bus.btn_level[1] !== (n >= 10) || bus.down_pulse !== (n == 11) || bus.up_pulse !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce n=%0d got lvl=%b dn=%b up=%b want lvl=%b dn=%b up=0", n,
                 bus.btn_level[1], bus.down_pulse, bus.up_pulse, n >= 10, n == 11);
      end
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL bounce_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
    end
    bus.btn = 2'b00;
    for (int n = 0; n < 10; n++) tick();
  endtask

  task automatic test_short_press();
    int ups;
    ups = 0;
    for (int n = 1; n <= 40; n++) begin
      bus.btn = (n <= 10) ? 2'b01 : 2'b00;
      tick();
      if (bus.up_pulse === 1'b1) ups++;
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL short_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
      if (n == 15 || n == 16) begin
        n_vec++;
        if (bus.btn_level[0] !== (n == 15)) begin
          n_bad++;
          $display("FAIL short_level_fall n=%0d got %b want %b", n, bus.btn_level[0], n == 15);
        end
      end
    end
    n_vec++;
    if (ups != 1) begin
      n_bad++;
      $display("FAIL short_pulse_count got %0d want 1", ups);
    end
  endtask

  task automatic test_overlap();
    int downs;
    downs = 0;
    for (int n = 1; n <= 140; n++) begin
      bus.btn = (n <= 40) ? 2'b01 : (n <= 70) ? 2'b11 : (n <= 120) ? 2'b10 : 2'b00;
      tick();
      if (bus.down_pulse === 1'b1) downs++;
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL overlap_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
      n_vec++;
      if (bus.up_pulse === 1'b1 && bus.down_pulse === 1'b1) begin
        n_bad++;
        $display("FAIL overlap_exclusive n=%0d got up=1 dn=1 want not both", n);
      end
    end
    // btn[1] level rises at 46; its schedule ages 0,20,28 fall while both held,
    // btn[0] falls at 76, so down pulses land at 83,91,...,123 (levels fall at 126)
    n_vec++;
    if (downs != 6) begin
      n_bad++;
      $display("FAIL overlap_down_count got %0d want 6", downs);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_up;
    bus.btn = 2'b01;
    for (int n = 0; n < 15; n++) tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if ({bus.btn_level, bus.up_pulse, bus.down_pulse} !== 4'b0000) begin
      n_bad++;
      $display("FAIL midreset_clear got lvl=%b up=%b dn=%b want 00/0/0",
               bus.btn_level, bus.up_pulse, bus.down_pulse);
    end
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_up = (n == 7 || n == 27 || n == 35);
      n_vec++;
      if (bus.up_pulse !== exp_up) begin
        n_bad++;
        $display("FAIL midreset_schedule n=%0d got up=%b want %b", n, bus.up_pulse, exp_up);
      end
      n_vec++;
      if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
        n_bad++;
        $display("FAIL midreset_model n=%0d got %b/%b/%b want %b/%b/%b", n,
                 bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
      end
    end
    bus.btn = 2'b00;
    for (int n = 0; n < 10; n++) tick();
  endtask

  task automatic test_random();
    int hold;
    for (int blk = 0; blk < 150; blk++) begin
      bus.btn = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(5, 60));
      for (int n = 0; n < hold; n++) begin
        rst = ($urandom_range(0, 199) == 0);
        tick();
        n_vec++;
        if (bus.btn_level !== m_lvl || bus.up_pulse !== m_up || bus.down_pulse !== m_dn) begin
          n_bad++;
          $display("FAIL random_model cyc=%0d got %b/%b/%b want %b/%b/%b", cyc,
                   bus.btn_level, bus.up_pulse, bus.down_pulse, m_lvl, m_up, m_dn);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.btn = 2'b00;
    m_rise[0] = 0;
    m_rise[1] = 0;
    test_reset();
    test_hold_repeat();
    test_bounce();
    test_short_press();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
